idli_pred_ctrl_m: RTL

IDLI_PRED_CTRL_M -- requirements
Module: idli_pred_ctrl_m

---
 rtl/idli_pred_ctrl_m.sv | 121 ++++++++++++
 1 files changed

// File: rtl/idli_pred_ctrl_m.sv
// Predicate compare controller: compares two operands nibble-serially (LSB nibble
// first) and writes the EQ/NE/LTU/GEU result into predicate register P0..P2 over the PRF Q port.
module idli_pred_ctrl_m #(
    parameter int NIBBLES = 4
) (
    input  logic       i_pctl_gck,
    input  logic       i_pctl_rst,
    input  logic       i_pctl_req_vld,
    output logic       o_pctl_req_rdy,
    input  logic [1:0] i_pctl_req_preg,
    input  logic [1:0] i_pctl_req_op,
    input  logic [3:0] i_pctl_a,
    input  logic [3:0] i_pctl_b,
    input  logic       i_pctl_flush,
    output logic [1:0] o_pctl_q,
    output logic       o_pctl_q_wr_en,
    output logic       o_pctl_q_data,
    output logic       o_pctl_done,
    input  logic [1:0] i_pctl_chk_preg,
    output logic       o_pctl_chk_busy,
    output logic [1:0] o_pctl_dbg_state
);

    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        WR   = 2'd2
    } state_t;

    // Handshake: a request transfers on any rising edge where i_pctl_req_vld and
    // o_pctl_req_rdy are both high; that same cycle carries nibble 0 of A and B.
    state_t        state;
    logic [CW-1:0] cnt;
    logic          eq;
    logic          ltu;
    logic [1:0]    preg;
    logic [1:0]    op;

    logic accept;
    logic nib_eq;
    logic nib_lt;
    logic result;
    logic in_wr;

    assign nib_eq = (i_pctl_a == i_pctl_b);
    assign nib_lt = (i_pctl_a < i_pctl_b);
    assign accept = i_pctl_req_vld & o_pctl_req_rdy;

    always_ff @(posedge i_pctl_gck or posedge i_pctl_rst) begin
        if (i_pctl_rst) begin
            state <= IDLE;
            cnt   <= '0;
            eq    <= 1'b0;
            ltu   <= 1'b0;
            preg  <= 2'd0;
            op    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CMP;
                        cnt   <= CW'(1);
                        eq    <= nib_eq;
                        ltu   <= nib_lt;
                        preg  <= i_pctl_req_preg;
                        op    <= i_pctl_req_op;
                    end
                end
                CMP: begin
                    if (i_pctl_flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        eq  <= eq & nib_eq;
                        // Higher nibbles override; an equal nibble keeps the lower-order verdict.
                        ltu <= nib_lt | (nib_eq & ltu);
                        if (cnt == LAST) begin
                            state <= WR;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                WR: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        result = 1'b0;
        case (op)
            2'b00:   result = eq;
            2'b01:   result = ~eq;
            2'b10:   result = ltu;
            default: result = ~ltu;
        endcase
    end

    // Flush wins over the write slot, so the retire pulse is suppressed in that cycle.
    assign in_wr            = (state == WR) & ~i_pctl_flush;
    assign o_pctl_req_rdy   = (state == IDLE) & ~i_pctl_flush;
    assign o_pctl_done      = in_wr;
    assign o_pctl_q_wr_en   = in_wr & (preg != 2'd3);
    assign o_pctl_q         = (state == WR) ? preg : 2'd0;
    assign o_pctl_q_data    = (state == WR) ? result : 1'b0;
    assign o_pctl_chk_busy  = ((state == CMP) || (state == WR)) &&
                              (preg == i_pctl_chk_preg) && (preg != 2'd3);
    assign o_pctl_dbg_state = state;

endmodule
